// File: rtl/mips_pkg.sv
// Purpose : shared constants and encodings for the fetch-stage next-PC logic.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int               PC_W      = 13;
    localparam logic [PC_W-1:0]  RESET_PC  = 13'h0000;
    localparam int               RAS_DEPTH = 4;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Winning redirect source for the current cycle, highest priority first.
    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_JR     = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_BRANCH = 3'd3,
        SRC_PEND   = 3'd4
    } redir_src_t;

endpackage

// File: rtl/ras_stack.sv
// Purpose : circular return-address stack; a push when full overwrites the oldest entry.
// Latency : top_dat is combinational from state; push/pop take effect on the next rising edge.
// Backpressure: none; a pop on an empty stack is ignored, a push and a pop together is a push.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the stack)
//   push, push_dat  write push_dat as the new top
//   pop             discard the current top
//   top_dat         current top entry (undefined content when empty)
//   empty, full     occupancy flags
module ras_stack #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] top_dat,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_sp;     // next slot to write
    logic [CW-1:0] r_cnt;    // live entries, saturates at DEPTH
    logic [PW-1:0] w_sp_inc;
    logic [PW-1:0] w_sp_dec;

    // Explicit wrap so non-power-of-two depths still behave circularly.
    assign w_sp_inc = (r_sp == PW'(DEPTH - 1)) ? '0 : r_sp + PW'(1);
    assign w_sp_dec = (r_sp == '0) ? PW'(DEPTH - 1) : r_sp - PW'(1);

    assign top_dat = r_mem[w_sp_dec];
    assign empty   = (r_cnt == '0);
    assign full    = (r_cnt == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp  <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_sp <= w_sp_inc;
            if (!full) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (pop && !empty) begin
            r_sp  <= w_sp_dec;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Storage needs no reset: occupancy is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_sp] <= push_dat;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Purpose : next fetch address select (increment/hold/branch/jump/jr) with redirect latching across holds.
// Latency : pcNext is combinational; flush and fetch_valid are registered (one edge after the cause).
// Backpressure: stall or !imem_ready holds pcNext at pcResult; redirects seen meanwhile are kept pending.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   pcResult                       current PC register value
//   stall, imem_ready              hold request / instruction memory accept
//   branch_taken, branch_target    taken branch from EX
//   jump, jump_target, jal         J/JAL in decode (jal marks a call)
//   jr, jr_target                  JR in decode with register-file target
//   pcNext                         next PC toward the PC register
//   fetch_valid                    current pcResult is a real fetch
//   flush                          one-cycle pulse: a redirect was applied
//   link_addr                      pcResult+1 for JAL writeback
//
// Optional: define RAS_EN to build a RAS_DEPTH-entry return-address stack that
// predicts JR targets from JAL link addresses.
module pc_next_unit #(
    parameter int                   PC_W      = mips_pkg::PC_W,
    parameter logic [PC_W-1:0]      RESET_PC  = mips_pkg::RESET_PC,
    parameter int                   RAS_DEPTH = mips_pkg::RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pcResult,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jal,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] pcNext,
    output logic            fetch_valid,
    output logic            flush,
    output logic [PC_W-1:0] link_addr
);

    import mips_pkg::*;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_pend_valid;
    logic [PC_W-1:0] r_pend_target;
    logic            r_fetch_valid;
    logic            r_flush;

    logic            w_hold;
    logic            w_live;       // redirects are only meaningful outside BOOT
    logic            w_adv;        // this cycle moves the PC
    logic            w_new_redir;
    redir_src_t      w_src;
    logic [PC_W-1:0] w_jr_eff;
    logic [PC_W-1:0] w_target;

    assign w_hold      = stall | ~imem_ready;
    assign w_live      = (r_state != ST_BOOT);
    assign w_adv       = w_live & ~w_hold;
    assign w_new_redir = w_live & (jr | jump | branch_taken);
    assign link_addr   = pcResult + PC_W'(1);

`ifdef RAS_EN
    logic            w_ras_empty;
    logic            w_ras_full;
    logic [PC_W-1:0] w_ras_top;
    logic            w_push;
    logic            w_pop;
    logic            r_push_done;  // call already pushed while this redirect was held
    logic            r_pop_done;   // return already popped while held; value sits in r_pend_target

    // A held decode keeps jump/jr asserted for many cycles; touch the stack
    // only once per event. jr outranks jal, so a simultaneous pair never pushes.
    assign w_push = w_live & jump & jal & ~jr & ~r_push_done;
    assign w_pop  = w_live & jr & ~w_ras_empty & ~r_pop_done;

    always_comb begin
        w_jr_eff = jr_target;
        if (r_pop_done) begin
            w_jr_eff = r_pend_target;
        end else if (!w_ras_empty) begin
            w_jr_eff = w_ras_top;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_adv) begin
            r_push_done <= 1'b0;
            r_pop_done  <= 1'b0;
        end else begin
            if (w_push) r_push_done <= 1'b1;
            if (w_pop)  r_pop_done  <= 1'b1;
        end
    end

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .push_dat (link_addr),
        .pop      (w_pop),
        .top_dat  (w_ras_top),
        .empty    (w_ras_empty),
        .full     (w_ras_full)
    );

    logic w_unused_ras_full;
    assign w_unused_ras_full = w_ras_full;
`else
    logic w_unused_jal;
    assign w_unused_jal = jal;
    assign w_jr_eff     = jr_target;
`endif

    // Redirect source priority and its target address.
    always_comb begin
        w_src    = SRC_NONE;
        w_target = link_addr;
        if (w_live && jr) begin
            w_src    = SRC_JR;
            w_target = w_jr_eff;
        end else if (w_live && jump) begin
            w_src    = SRC_JUMP;
            w_target = jump_target;
        end else if (w_live && branch_taken) begin
            w_src    = SRC_BRANCH;
            w_target = branch_target;
        end else if (w_live && r_pend_valid) begin
            w_src    = SRC_PEND;
            w_target = r_pend_target;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN,
            ST_HOLD: w_state_nxt = w_hold ? ST_HOLD : ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Output logic.
    always_comb begin
        pcNext = w_target;
        if (reset || r_state == ST_BOOT) begin
            pcNext = RESET_PC;
        end else if (w_hold) begin
            pcNext = pcResult;
        end
    end

    // Pending redirect, flush pulse and fetch_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_flush <= w_adv & (w_src != SRC_NONE);
            if (r_state == ST_BOOT) begin
                r_fetch_valid <= 1'b1;
            end
            if (w_adv) begin
                // Either consumed now or superseded by a newer redirect.
                r_pend_valid <= 1'b0;
            end else if (w_new_redir) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_target;
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign flush       = r_flush;

endmodule
